// File: rtl/nr_program_loader_pkg.sv
// Shared types and constants for the nR program loader: FSM state encoding,
// segment select, frame command bytes and default bus widths.
package nr_program_loader_pkg;

  // Default memory geometry: 2**8 bytes per memory, byte-wide stream.
  localparam int LOADER_ADDR_W = 8;
  localparam int LOADER_DATA_W = 8;

  // Command bytes recognised in IDLE.
  localparam logic [7:0] CMD_IM  = 8'hA5;  // load instruction memory
  localparam logic [7:0] CMD_DM  = 8'h5A;  // load data memory
  localparam logic [7:0] CMD_RUN = 8'hFF;  // release core reset
  localparam logic [7:0] CMD_CLR = 8'hC3;  // clear sticky error

  // A LEN byte of zero means a full 256-byte payload, so the byte counter
  // needs one more bit than the stream byte.
  localparam bit LEN_ZERO_IS_256 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_RUN
  } state_t;

  typedef enum logic {
    SEG_IM,
    SEG_DM
  } seg_t;

  // Payload byte count encoded by a LEN byte.
  function automatic logic [8:0] len_decode(input logic [7:0] len_byte);
    if (LEN_ZERO_IS_256 && len_byte == 8'h00) begin
      return 9'd256;
    end
    return {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/nr_program_loader_if.sv
// Byte-stream input, IM/DM write ports and core-control outputs of the
// program loader. The host side is the master, the loader is the slave.
interface nr_program_loader_if
  import nr_program_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
);

  // Stream handshake
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  // Instruction memory write port
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  // Data memory write port
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;

  // Core control and status
  logic              cpu_reset;
  logic              busy;
  logic              err;

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  im_we, im_addr, im_wdata,
    input  dm_we, dm_addr, dm_wdata,
    input  cpu_reset, busy, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output im_we, im_addr, im_wdata,
    output dm_we, dm_addr, dm_wdata,
    output cpu_reset, busy, err
  );

endinterface

// File: rtl/nr_program_loader_csum.sv
// Running modulo-2**W checksum of a frame payload. Cleared at the start of
// each payload, accumulates every data byte, and reports whether adding the
// trailing checksum byte brings the total to zero.
module nr_program_loader_csum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         add_en,
  input  logic [W-1:0] add_data,
  input  logic [W-1:0] check_data,
  output logic         sum_zero
);

  logic [W-1:0] acc_reg;
  logic [W-1:0] final_sum;

  // Accumulate payload bytes; clear wins over add so a new frame starts at 0.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_reg <= '0;
    end else if (add_en) begin
      acc_reg <= acc_reg + add_data;
    end
  end

  // Wrapping add of the checksum byte; the frame is good when it lands on 0.
  always_comb begin
    final_sum = acc_reg + check_data;
    sum_zero  = (final_sum == '0);
  end

endmodule

// File: rtl/nr_program_loader.sv
// nR program loader: parses a framed byte stream (CMD, ADDR, LEN, data,
// CSUM) and turns it into byte writes on the IM or DM write port. Holds the
// core in reset until an accepted RUN command with no pending error.
module nr_program_loader
  import nr_program_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W,
  parameter int DATA_W = LOADER_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  nr_program_loader_if.slave bus
);

  // The counter must hold the full 2**DATA_W payload length.
  localparam int CNT_W = DATA_W + 1;

  state_t            state_reg;
  seg_t              seg_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              in_ready_reg;
  logic              cpu_reset_reg;
  logic              busy_reg;
  logic              err_reg;

  logic              im_we_reg;
  logic [ADDR_W-1:0] im_addr_reg;
  logic [DATA_W-1:0] im_wdata_reg;
  logic              dm_we_reg;
  logic [ADDR_W-1:0] dm_addr_reg;
  logic [DATA_W-1:0] dm_wdata_reg;

  logic              accept;
  logic              csum_clr;
  logic              csum_add;
  logic              csum_ok;
  logic [CNT_W-1:0]  len_count;
  logic              last_data;

  // Handshake and per-state decode of the current input byte.
  always_comb begin
    accept    = bus.in_valid && in_ready_reg;
    csum_clr  = accept && (state_reg == ST_LEN);
    csum_add  = accept && (state_reg == ST_DATA);
    last_data = (cnt_reg == CNT_W'(1));
    if (bus.in_data == '0) begin
      len_count = CNT_W'(1) << DATA_W;
    end else begin
      len_count = CNT_W'(bus.in_data);
    end
  end

  nr_program_loader_csum #(
    .W (DATA_W)
  ) u_csum (
    .clk        (clk),
    .reset      (reset),
    .clr        (csum_clr),
    .add_en     (csum_add),
    .add_data   (bus.in_data),
    .check_data (bus.in_data),
    .sum_zero   (csum_ok)
  );

  // Frame FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      seg_reg       <= SEG_IM;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      cpu_reset_reg <= 1'b1;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      im_we_reg     <= 1'b0;
      im_addr_reg   <= '0;
      im_wdata_reg  <= '0;
      dm_we_reg     <= 1'b0;
      dm_addr_reg   <= '0;
      dm_wdata_reg  <= '0;
    end else begin
      // Write strobes are single-cycle pulses; address/data just hold.
      im_we_reg <= 1'b0;
      dm_we_reg <= 1'b0;

      if (accept) begin
        case (state_reg)
          ST_IDLE: begin
            if (bus.in_data == DATA_W'(CMD_IM)) begin
              seg_reg   <= SEG_IM;
              state_reg <= ST_ADDR;
              busy_reg  <= 1'b1;
            end else if (bus.in_data == DATA_W'(CMD_DM)) begin
              seg_reg   <= SEG_DM;
              state_reg <= ST_ADDR;
              busy_reg  <= 1'b1;
            end else if (bus.in_data == DATA_W'(CMD_RUN)) begin
              // A pending error blocks the release of the core.
              if (!err_reg) begin
                state_reg     <= ST_RUN;
                in_ready_reg  <= 1'b0;
                cpu_reset_reg <= 1'b0;
              end
            end else if (bus.in_data == DATA_W'(CMD_CLR)) begin
              err_reg <= 1'b0;
            end else begin
              err_reg <= 1'b1;
            end
          end

          ST_ADDR: begin
            ptr_reg   <= ADDR_W'(bus.in_data);
            state_reg <= ST_LEN;
          end

          ST_LEN: begin
            cnt_reg   <= len_count;
            state_reg <= ST_DATA;
          end

          ST_DATA: begin
            if (seg_reg == SEG_IM) begin
              im_we_reg    <= 1'b1;
              im_addr_reg  <= ptr_reg;
              im_wdata_reg <= bus.in_data;
            end else begin
              dm_we_reg    <= 1'b1;
              dm_addr_reg  <= ptr_reg;
              dm_wdata_reg <= bus.in_data;
            end
            // Pointer wraps naturally at the top of the address space.
            ptr_reg <= ptr_reg + ADDR_W'(1);
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (last_data) begin
              state_reg <= ST_CSUM;
            end
          end

          ST_CSUM: begin
            // Bad frames only flag the error; written bytes stay in memory.
            if (!csum_ok) begin
              err_reg <= 1'b1;
            end
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end

          ST_RUN: begin
            // in_ready is low here, so no byte is ever accepted in RUN.
            state_reg <= ST_RUN;
          end

          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Drive the interface from the registered state.
  always_comb begin
    bus.in_ready  = in_ready_reg;
    bus.cpu_reset = cpu_reset_reg;
    bus.busy      = busy_reg;
    bus.err       = err_reg;
    bus.im_we     = im_we_reg;
    bus.im_addr   = im_addr_reg;
    bus.im_wdata  = im_wdata_reg;
    bus.dm_we     = dm_we_reg;
    bus.dm_addr   = dm_addr_reg;
    bus.dm_wdata  = dm_wdata_reg;
  end

endmodule

// File: tb/tb_nr_program_loader.sv
// Self-checking bench for nr_program_loader: directed frames plus randomized
// frames with random in_valid gaps, checked against a frame-level model.
module tb_nr_program_loader;
  import nr_program_loader_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  nr_program_loader_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  nr_program_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Strobe counters kept by the monitor; expected counts kept by the model.
  int im_seen = 0;
  int dm_seen = 0;
  int im_exp  = 0;
  int dm_exp  = 0;

  logic         model_err;
  logic [7:0]   frame_data [$];
  logic [255:0] im_cov;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Count every write strobe; both at once is never allowed.
  always @(negedge clk) begin
    if (bus.im_we) im_seen++;
    if (bus.dm_we) dm_seen++;
    if (bus.im_we && bus.dm_we) check_eq("one_strobe", {31'd0, bus.dm_we}, 32'd0);
  end

  // Send one byte starting at a negedge, after 'gap' idle cycles. Returns at
  // the negedge after acceptance and checks the write that byte should cause
  // (exp_kind 0 = none, 1 = IM, 2 = DM).
  task automatic send_byte(input logic [7:0] b, input int gap, input int exp_kind,
                           input logic [7:0] exp_addr, input logic [7:0] exp_data);
    int waited;
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_eq("gap_no_we", {30'd0, bus.im_we, bus.dm_we}, 32'd0);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    waited = 0;
    while (!bus.in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) check_eq("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    case (exp_kind)
      1: begin
        check_eq("im_we", {30'd0, bus.im_we, bus.dm_we}, 32'd2);
        check_eq("im_addr", {24'd0, bus.im_addr}, {24'd0, exp_addr});
        check_eq("im_wdata", {24'd0, bus.im_wdata}, {24'd0, exp_data});
        if (bus.im_we) im_cov[bus.im_addr] = 1'b1;
      end
      2: begin
        check_eq("dm_we", {30'd0, bus.im_we, bus.dm_we}, 32'd1);
        check_eq("dm_addr", {24'd0, bus.dm_addr}, {24'd0, exp_addr});
        check_eq("dm_wdata", {24'd0, bus.dm_wdata}, {24'd0, exp_data});
      end
      default: check_eq("no_we", {30'd0, bus.im_we, bus.dm_we}, 32'd0);
    endcase
  endtask

  // Send a whole frame using frame_data as payload. The checksum is the
  // two's complement of the payload sum, offset by 'delta' (nonzero = bad).
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] start,
                            input logic [7:0] len, input logic [7:0] delta, input int max_gap);
    int          kind;
    int          n;
    logic [7:0]  sum;
    logic [7:0]  cs;
    kind = (cmd == CMD_IM) ? 1 : 2;
    n    = (len == 8'd0) ? 256 : int'(len);
    sum  = 8'd0;
    send_byte(cmd, $urandom_range(0, max_gap), 0, 8'd0, 8'd0);
    check_eq("busy_frame", {31'd0, bus.busy}, 32'd1);
    send_byte(start, $urandom_range(0, max_gap), 0, 8'd0, 8'd0);
    send_byte(len, $urandom_range(0, max_gap), 0, 8'd0, 8'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(frame_data[i], $urandom_range(0, max_gap), kind, 8'(start + 8'(i)), frame_data[i]);
      sum = sum + frame_data[i];
      if (kind == 1) im_exp++; else dm_exp++;
    end
    cs = 8'(8'd0 - sum) + delta;
    send_byte(cs, $urandom_range(0, max_gap), 0, 8'd0, 8'd0);
    if (delta != 8'd0) model_err = 1'b1;
    check_eq("frame_err", {31'd0, bus.err}, {31'd0, model_err});
    check_eq("frame_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("frame_cpu_rst", {31'd0, bus.cpu_reset}, 32'd1);
    check_eq("im_count", im_seen, im_exp);
    check_eq("dm_count", dm_seen, dm_exp);
    $display("frame cmd=%h addr=%h len=%0d csum=%h err=%0b", cmd, start, n, cs, bus.err);
  endtask

  task automatic clear_err();
    send_byte(CMD_CLR, 0, 0, 8'd0, 8'd0);
    model_err = 1'b0;
    check_eq("clr_err", {31'd0, bus.err}, 32'd0);
  endtask

  initial begin
    logic [7:0] seg_cmd;
    logic [7:0] delta;

    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    model_err    = 1'b0;
    im_cov       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check_eq("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_err", {31'd0, bus.err}, 32'd0);
    check_eq("rst_we", {30'd0, bus.im_we, bus.dm_we}, 32'd0);
    check_eq("rst_im_bus", {16'd0, bus.im_addr, bus.im_wdata}, 32'd0);
    check_eq("rst_dm_bus", {16'd0, bus.dm_addr, bus.dm_wdata}, 32'd0);
    $display("reset state checked");

    // IM frame: [0]=C7 [1]=11 [2]=C8
    frame_data = '{8'hC7, 8'h11, 8'hC8};
    send_frame(CMD_IM, 8'h00, 8'd3, 8'd0, 0);

    // DM frame wrapping FE -> FF -> 00
    frame_data = '{8'h01, 8'h02, 8'h03};
    send_frame(CMD_DM, 8'hFE, 8'd3, 8'd0, 0);

    // Bad checksum: AA followed by CSUM 00 (correct would be 56)
    frame_data = '{8'hAA};
    send_frame(CMD_DM, 8'h10, 8'd1, 8'hAA, 0);
    send_byte(CMD_RUN, 0, 0, 8'd0, 8'd0);
    check_eq("run_blocked_cpu", {31'd0, bus.cpu_reset}, 32'd1);
    check_eq("run_blocked_rdy", {31'd0, bus.in_ready}, 32'd1);
    check_eq("run_blocked_err", {31'd0, bus.err}, 32'd1);
    clear_err();

    // Unknown command sets err, no writes, stays idle
    send_byte(8'h12, 0, 0, 8'd0, 8'd0);
    model_err = 1'b1;
    check_eq("unk_err", {31'd0, bus.err}, 32'd1);
    check_eq("unk_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("unk_im_count", im_seen, im_exp);
    check_eq("unk_dm_count", dm_seen, dm_exp);
    $display("unknown command 12 handled, err=%0b", bus.err);

    // Reset after 2 of 5 data bytes (err is still set from the unknown command)
    send_byte(CMD_DM, 0, 0, 8'd0, 8'd0);
    send_byte(8'h40, 1, 0, 8'd0, 8'd0);
    send_byte(8'd5, 0, 0, 8'd0, 8'd0);
    send_byte(8'h9A, 2, 2, 8'h40, 8'h9A);
    send_byte(8'h9B, 0, 2, 8'h41, 8'h9B);
    dm_exp += 2;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_err = 1'b0;
    check_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("mid_rst_cpu", {31'd0, bus.cpu_reset}, 32'd1);
    check_eq("mid_rst_err", {31'd0, bus.err}, 32'd0);
    bus.in_data = 8'h9C;
    repeat (5) @(negedge clk);
    check_eq("mid_rst_dm_count", dm_seen, dm_exp);
    check_eq("mid_rst_im_count", im_seen, im_exp);
    $display("reset mid-frame checked");

    // LEN=0: 256 IM writes covering every address
    frame_data = {};
    for (int i = 0; i < 256; i++) frame_data.push_back(8'($urandom));
    im_cov = '0;
    send_frame(CMD_IM, 8'($urandom), 8'd0, 8'd0, 0);
    check_eq("len0_coverage", $countones(im_cov), 32'd256);

    // Randomized frames with gapped in_valid and occasional bad checksums
    for (int f = 0; f < 12; f++) begin
      seg_cmd    = $urandom_range(0, 1) ? CMD_IM : CMD_DM;
      frame_data = {};
      for (int i = 0; i < 24; i++) frame_data.push_back(8'($urandom));
      delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      send_frame(seg_cmd, 8'($urandom), 8'($urandom_range(1, 24)), delta, 3);
      if (model_err) clear_err();
    end

    // RUN releases the core one cycle after acceptance
    send_byte(CMD_RUN, 1, 0, 8'd0, 8'd0);
    check_eq("run_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
    check_eq("run_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check_eq("run_busy", {31'd0, bus.busy}, 32'd0);
    bus.in_data  = CMD_IM;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("run_hold_cpu", {31'd0, bus.cpu_reset}, 32'd0);
    check_eq("run_hold_rdy", {31'd0, bus.in_ready}, 32'd0);
    check_eq("run_hold_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("run_no_writes", im_seen + dm_seen, im_exp + dm_exp);
    $display("run command checked");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
